// File: rtl/priority_encoder_4bit.sv
// -----------------------------------------------------------------------------
// priority_encoder_4bit
//   Picks the highest-priority set bit of a 4-bit request vector. The winner is
//   presented as a one-hot grant, as a binary index, and with a valid flag.
//   MSB_FIRST chooses which end of the vector wins. OUT_REG chooses between
//   registered outputs (1-cycle latency) and a purely combinational path.
// -----------------------------------------------------------------------------
module priority_encoder_4bit #(
  parameter bit MSB_FIRST = 1'b1,  // 1: in[3] wins, 0: in[0] wins
  parameter bit OUT_REG   = 1'b1   // 1: registered outputs, 0: combinational
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in,
  output logic [3:0] out,
  output logic [1:0] idx,
  output logic       valid
);

  logic [3:0] grant_d;
  logic [1:0] idx_d;
  logic       valid_d;

  // Encode the request vector into grant/index/valid for the selected priority order.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave it unassigned and infer a latch.
    grant_d = 4'b0000;
    idx_d   = 2'd0;
    valid_d = |in;
    if (MSB_FIRST) begin
      priority casez (in)
        4'b1???: begin grant_d = 4'b1000; idx_d = 2'd3; end
        4'b01??: begin grant_d = 4'b0100; idx_d = 2'd2; end
        4'b001?: begin grant_d = 4'b0010; idx_d = 2'd1; end
        4'b0001: begin grant_d = 4'b0001; idx_d = 2'd0; end
        default: begin grant_d = 4'b0000; idx_d = 2'd0; end
      endcase
    end else begin
      priority casez (in)
        4'b???1: begin grant_d = 4'b0001; idx_d = 2'd0; end
        4'b??10: begin grant_d = 4'b0010; idx_d = 2'd1; end
        4'b?100: begin grant_d = 4'b0100; idx_d = 2'd2; end
        4'b1000: begin grant_d = 4'b1000; idx_d = 2'd3; end
        default: begin grant_d = 4'b0000; idx_d = 2'd0; end
      endcase
    end
  end

  if (OUT_REG) begin : g_reg
    logic [3:0] out_q;
    logic [1:0] idx_q;
    logic       valid_q;

    // Capture the encoded result on each rising edge; reset clears it at once.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        out_q   <= 4'b0000;
        idx_q   <= 2'd0;
        valid_q <= 1'b0;
      end else begin
        out_q   <= grant_d;
        idx_q   <= idx_d;
        valid_q <= valid_d;
      end
    end

    assign out   = out_q;
    assign idx   = idx_q;
    assign valid = valid_q;
  end else begin : g_comb
    // The clock has no job here; reset still forces the outputs to zero.
    logic unused_clk;
    assign unused_clk = clk;

    assign out   = rst_n ? grant_d : 4'b0000;
    assign idx   = rst_n ? idx_d   : 2'd0;
    assign valid = rst_n ? valid_d : 1'b0;
  end

endmodule

// File: tb/tb_priority_encoder_4bit.sv
// -----------------------------------------------------------------------------
// tb_priority_encoder_4bit
//   Three builds share one request input: MSB-first registered, LSB-first
//   registered and MSB-first combinational. Expected responses for the
//   registered builds are queued on each rising edge and popped by a monitor on
//   the falling edge; the combinational build is compared against the model of
//   the current input.
// -----------------------------------------------------------------------------
module tb_priority_encoder_4bit;

  typedef struct packed {
    logic [3:0] out;
    logic [1:0] idx;
    logic       valid;
  } resp_t;

  typedef struct packed {
    resp_t msb;
    resp_t lsb;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] in_r = 4'b1111;

  logic [3:0] msb_out, lsb_out, cmb_out;
  logic [1:0] msb_idx, lsb_idx, cmb_idx;
  logic       msb_valid, lsb_valid, cmb_valid;

  int checks = 0;
  int failures = 0;
  bit done = 1'b0;
  exp_t sb_q[$];

  priority_encoder_4bit #(.MSB_FIRST(1'b1), .OUT_REG(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in(in_r), .out(msb_out), .idx(msb_idx), .valid(msb_valid));
  priority_encoder_4bit #(.MSB_FIRST(1'b0), .OUT_REG(1'b1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in(in_r), .out(lsb_out), .idx(lsb_idx), .valid(lsb_valid));
  priority_encoder_4bit #(.MSB_FIRST(1'b1), .OUT_REG(1'b0)) dut_cmb (
    .clk(clk), .rst_n(rst_n), .in(in_r), .out(cmb_out), .idx(cmb_idx), .valid(cmb_valid));

  always #5 clk = ~clk;

  // Reference model: winner found arithmetically (log2 of the value, or the
  // isolated lowest set bit), not by a priority case table.
  function automatic resp_t model(input logic [3:0] v, input bit msb_first, input logic rst);
    resp_t r;
    int    n;
    int    k;
    r = '0;
    if (rst && v != 4'd0) begin
      n = int'(v);
      if (msb_first) begin
        k = 0;
        while (n > 1) begin n = n / 2; k++; end
      end else begin
        n = n & (-n);
        k = 0;
        while (n > 1) begin n = n / 2; k++; end
      end
      r.idx   = 2'(k);
      r.out   = 4'(1 << k);
      r.valid = 1'b1;
    end
    return r;
  endfunction

  task automatic check(input string name, input resp_t act, input resp_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got out=%b idx=%0d valid=%b, expected out=%b idx=%0d valid=%b",
               name, act.out, act.idx, act.valid, exp.out, exp.idx, exp.valid);
    end
  endtask

  // Scoreboard producer: the response each registered build owes for this edge.
  always @(posedge clk) begin
    if (!done) sb_q.push_back('{msb: model(in_r, 1'b1, rst_n), lsb: model(in_r, 1'b0, rst_n)});
  end

  // Monitor: pop and compare on the falling edge, away from the sampling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!done) begin
      if (sb_q.size() == 0) begin
        failures++;
        checks++;
        $display("FAIL scoreboard: queue empty at time %0t, expected one entry", $time);
      end else begin
        e = sb_q.pop_front();
        check("msb_reg", '{out: msb_out, idx: msb_idx, valid: msb_valid}, e.msb);
        check("lsb_reg", '{out: lsb_out, idx: lsb_idx, valid: lsb_valid}, e.lsb);
      end
      check("msb_comb", '{out: cmb_out, idx: cmb_idx, valid: cmb_valid}, model(in_r, 1'b1, rst_n));
    end
  end

  // Change the input between edges, clear of the monitor's sampling point.
  task automatic drive(input logic [3:0] v);
    @(negedge clk);
    #2 in_r = v;
  endtask

  // Invariant: the one-hot output always agrees with idx/valid.
  always @(negedge clk) begin
    if (!done) begin
      checks++;
      if (msb_out !== (msb_valid ? 4'(1 << msb_idx) : 4'b0000)) begin
        failures++;
        $display("FAIL onehot_msb: out=%b idx=%0d valid=%b", msb_out, msb_idx, msb_valid);
      end
    end
  end

  initial begin
    logic [3:0] seq [5];
    seq[0] = 4'b1111; seq[1] = 4'b1010; seq[2] = 4'b0011; seq[3] = 4'b0000; seq[4] = 4'b0001;

    // Reset held with all requests set: outputs stay zero across several edges.
    repeat (4) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Priority sequence, one edge per value.
    foreach (seq[i]) drive(seq[i]);

    // Every input value.
    for (int v = 0; v < 16; v++) drive(4'(v));

    // Asynchronous reset pulse between edges with out=0100 steady.
    drive(4'b0100);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_msb", '{out: msb_out, idx: msb_idx, valid: msb_valid}, resp_t'(7'b0));
    check("async_rst_lsb", '{out: lsb_out, idx: lsb_idx, valid: lsb_valid}, resp_t'(7'b0));
    check("async_rst_comb", '{out: cmb_out, idx: cmb_idx, valid: cmb_valid}, resp_t'(7'b0));
    #1 rst_n = 1'b1;

    // Latency: change just after an edge; old value must persist until the next edge.
    drive(4'b0001);
    @(posedge clk);
    #1 in_r = 4'b0100;
    check("latency_hold", '{out: msb_out, idx: msb_idx, valid: msb_valid}, model(4'b0001, 1'b1, 1'b1));
    @(posedge clk);
    #1;
    check("latency_update", '{out: msb_out, idx: msb_idx, valid: msb_valid}, model(4'b0100, 1'b1, 1'b1));

    // LSB-first spot values.
    drive(4'b1010);
    drive(4'b1000);

    // Randomised stimulus.
    for (int i = 0; i < 200; i++) drive(4'($urandom_range(0, 15)));

    @(negedge clk);
    #1 done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, limit 100000 reached");
    $fatal(1, "timeout");
  end

endmodule
